rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//  Reset request arbiter and staged release sequencer. Merges NREQ synchronous
//  reset requests (button, watchdog, software, clock-loss) into one reset event.
//  Holds all reset domains for a minimum time, then releases them in order:
//  stage 0 first (clocking/memory), the last stage last (CPU).
//  Latches the reset cause so software can read it after restart. Sits between
//  the request sources and the per-domain reset nets.
// PARAMETERS
//  NREQ        4   number of reset request inputs
//  STAGES      3   number of staged reset outputs
//  HOLD_CYCLES 16  minimum assert time after the last active request (>=2)
//  STAGE_GAP   8   cycles between successive stage releases (>=1)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          async active-low reset (power-on)
//  req          in   NREQ       level reset requests, active-high, already synchronous to clk
//  cause_clr    in   1          1-cycle pulse: clear cause register (honoured in IDLE only)
//  rst_stage_n  out  STAGES     per-domain resets, active-low, registered
//  busy         out  1          1 while any stage is held (state != IDLE)
//  cause        out  NREQ+1     sticky reset cause; bit NREQ = power-on, bit i = req[i]
// BEHAVIOUR
//  - States: HOLD, RELEASE, IDLE. Counter width $clog2(max(HOLD_CYCLES,STAGE_GAP))+1.
//  - Stage index width $clog2(STAGES)+1. All outputs are registered.
//  - rst_n low (async): state=HOLD, cnt=0, stage=0, rst_stage_n=all 0, busy=1,
//    cause={1'b1, NREQ'b0}.
//  - Any edge where |req=1 (any state): next state HOLD, cnt=0, stage=0,
//    rst_stage_n=all 0 at that edge, busy=1.
//  - Any edge where |req=1 also sets cause |= {1'b0, req}. Bits accumulate
//    until cleared.
//  - HOLD, req==0: cnt++. At the edge where cnt==HOLD_CYCLES-1: rst_stage_n[0]=1,
//    cnt=0, stage=1. If STAGES==1 go to IDLE, else go to RELEASE.
//  - So stage 0 releases on the HOLD_CYCLES-th consecutive edge with req==0.
//  - RELEASE, req==0: cnt++. At the edge where cnt==STAGE_GAP-1:
//    rst_stage_n[stage]=1, stage++, cnt=0. After releasing stage STAGES-1, go to IDLE.
//  - Released stages stay released until the next request or rst_n.
//    Release order is strictly ascending.
//  - IDLE: rst_stage_n=all 1, busy=0; holds until req or rst_n.
//  - cause_clr in IDLE: cause=0 at that edge. Ignored when not IDLE.
//  - cause_clr together with |req at the same edge: the request wins and the new
//    req bits are ORed into the old cause (no clear).
//  - A request mid-RELEASE re-asserts every stage, including already-released
//    ones, and restarts HOLD from cnt=0.
//  - A request held continuously keeps cnt at 0, so reset stays asserted for the
//    whole duration.
//  - No glitches: each rst_stage_n bit changes at most once per clk edge.
// TESTING
//  1 Power-on: rst_n low 3 cycles, release; req=0 (HOLD=16, GAP=8, STAGES=3) ->
//    rst_stage_n 000 until edge 16; 001 at edge 16; 011 at edge 24; 111 and busy=0
//    at edge 32. cause=5'b10000 throughout.
//  2 Watchdog: in IDLE, cause_clr pulse then req=4'b0010 for 5 edges (last high
//    edge m) -> cause=00000 then 00010; rst_stage_n=000 from the first high edge;
//    release edges m+16/m+24/m+32.
//  3 Re-trigger: req[2] pulse 1 cycle during RELEASE with stage 0 released ->
//    rst_stage_n=000 at that edge; cause bit 2 set; full sequence restarts
//    (m+16/24/32).
//  4 Simultaneous: req=4'b1001 for one edge, then req=4'b0100 during HOLD ->
//    cause=01101; HOLD restarts from the second request; one sequence only.
//  5 Clear gating: cause_clr while busy=1 -> cause unchanged. cause_clr in the same
//    edge as req[0] in IDLE -> cause = old|00001.
//  6 Async reset mid-RELEASE (rst_stage_n=011): rst_n low between edges ->
//    rst_stage_n=000 immediately (no clk edge); cause=10000; power-on timing as in 1.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: merges synchronous reset requests into one reset event, holds every
// reset domain for a minimum time, then releases the domains one by one in
// ascending order. It also latches which sources caused the reset.
module rst_seq #(
  parameter int NREQ        = 4,
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              cause_clr,
  output logic [STAGES-1:0] rst_stage_n,
  output logic              busy,
  output logic [NREQ:0]     cause
);

  // One counter serves both the hold time and the gap between stages.
  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int SW      = $clog2(STAGES) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_IDLE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [STAGES-1:0]   rst_stage_n_q, rst_stage_n_d;
  logic                busy_q, busy_d;
  logic [NREQ:0]       cause_q, cause_d;

  // State and output registers; power-on reset marks the cause as power-on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      stage_q       <= '0;
      rst_stage_n_q <= '0;
      busy_q        <= 1'b1;
      cause_q       <= {1'b1, {NREQ{1'b0}}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      rst_stage_n_q <= rst_stage_n_d;
      busy_q        <= busy_d;
      cause_q       <= cause_d;
    end
  end

  // Next-state logic: any request restarts the hold; otherwise count down the
  // hold time and then release one stage per gap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_d       = stage_q;
    rst_stage_n_d = rst_stage_n_q;
    cause_d       = cause_q;

    if (|req) begin
      // A request wins over everything, including a same-edge cause clear,
      // and re-asserts stages that were already released.
      state_d       = S_HOLD;
      cnt_d         = '0;
      stage_d       = '0;
      rst_stage_n_d = '0;
      cause_d       = cause_q | {1'b0, req};
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_stage_n_d[0] = 1'b1;
            cnt_d            = '0;
            stage_d          = SW'(1);
            state_d          = (STAGES == 1) ? S_IDLE : S_RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < STAGES; i++) begin
              if (stage_q == SW'(i)) rst_stage_n_d[i] = 1'b1;
            end
            cnt_d   = '0;
            stage_d = stage_q + SW'(1);
            if (stage_q == STAGE_LAST) state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_IDLE: begin
          rst_stage_n_d = '1;
          // Clearing is only honoured once the sequence has fully completed.
          if (cause_clr) cause_d = '0;
        end
        default: begin
          state_d       = S_HOLD;
          cnt_d         = '0;
          stage_d       = '0;
          rst_stage_n_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign rst_stage_n = rst_stage_n_q;
  assign busy        = busy_q;
  assign cause       = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: directed scenarios plus randomized requests, checked
// against a model that tracks consecutive quiet edges since the last request.
module tb_rst_seq;

  localparam int NREQ  = 4;
  localparam int STG   = 3;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int TOTAL = HOLD + (STG - 1) * GAP;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            cause_clr = 1'b0;
  logic [STG-1:0]  rst_stage_n;
  logic            busy;
  logic [NREQ:0]   cause;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int              quiet;     // consecutive req==0 edges since last request/reset (saturating)
  logic [NREQ:0]   m_cause;

  rst_seq #(.NREQ(NREQ), .STAGES(STG), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .cause_clr(cause_clr),
    .rst_stage_n(rst_stage_n),
    .busy(busy),
    .cause(cause)
  );

  always #5 clk = ~clk;

  function automatic logic [STG-1:0] exp_stage();
    logic [STG-1:0] e;
    for (int k = 0; k < STG; k++) e[k] = (quiet >= HOLD + k * GAP);
    return e;
  endfunction

  function automatic logic exp_busy();
    return (quiet < TOTAL);
  endfunction

  task automatic model_reset();
    quiet   = 0;
    m_cause = {1'b1, {NREQ{1'b0}}};
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic c);
    logic idle_before;
    idle_before = (quiet >= TOTAL);
    if (r != '0) begin
      quiet   = 0;
      m_cause = m_cause | {1'b0, r};
    end else begin
      if (idle_before && c) m_cause = '0;
      if (quiet < TOTAL) quiet++;
    end
  endtask

  // Drive one edge of stimulus, advance the model, sample 1 time unit later.
  task automatic tick(input logic [NREQ-1:0] r, input logic c);
    req       = r;
    cause_clr = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({rst_stage_n, busy, cause} !== {3'b000, 1'b1, 5'b10000}) begin
        fails++;
        $display("FAIL reset cycle %0d: got stage=%b busy=%b cause=%b, expected stage=000 busy=1 cause=10000",
                 e, rst_stage_n, busy, cause);
      end
    end
    rst_n = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_power_on();
    int fall_edge;
    fall_edge = -1;
    for (int e = 1; e <= TOTAL + 2; e++) begin
      tick('0, 1'b0);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL power_on edge %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
      if (busy === 1'b0 && fall_edge < 0) fall_edge = e;
    end
    tests++;
    if (fall_edge != 32) begin
      fails++;
      $display("FAIL power_on_busy_fall: got edge %0d, expected edge 32", fall_edge);
    end
    $display("[TB] test_power_on done, busy fell at edge %0d", fall_edge);
  endtask

  task automatic test_watchdog();
    tick('0, 1'b1);
    tests++;
    if (cause !== 5'b00000) begin
      fails++;
      $display("FAIL watchdog_clear: got cause=%b, expected 00000", cause);
    end
    for (int e = 0; e < 5 + TOTAL + 2; e++) begin
      tick((e < 5) ? 4'b0010 : 4'b0000, 1'b0);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL watchdog step %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
    end
    tests++;
    if (cause !== 5'b00010) begin
      fails++;
      $display("FAIL watchdog_cause: got cause=%b, expected 00010", cause);
    end
    $display("[TB] test_watchdog done");
  endtask

  task automatic test_retrigger();
    tick(4'b0001, 1'b0);
    for (int e = 0; e < HOLD + 2; e++) tick('0, 1'b0);
    tests++;
    if (rst_stage_n !== 3'b001) begin
      fails++;
      $display("FAIL retrigger_pre: got stage=%b, expected 001", rst_stage_n);
    end
    for (int e = 0; e < TOTAL + 3; e++) begin
      tick((e == 0) ? 4'b0100 : 4'b0000, 1'b0);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL retrigger step %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
    end
    $display("[TB] test_retrigger done, cause=%b", cause);
  endtask

  task automatic test_simultaneous();
    int rises;
    logic prev_busy;
    tick('0, 1'b1);
    rises = 0;
    prev_busy = busy;
    for (int e = 0; e < 7 + TOTAL + 2; e++) begin
      tick((e == 0) ? 4'b1001 : ((e == 6) ? 4'b0100 : 4'b0000), 1'b0);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL simultaneous step %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
      if (busy === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = busy;
    end
    tests++;
    if (cause !== 5'b01101 || rises != 1) begin
      fails++;
      $display("FAIL simultaneous_summary: got cause=%b sequences=%0d, expected cause=01101 sequences=1",
               cause, rises);
    end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_clear_gating();
    for (int e = 0; e < 2 * (TOTAL + 4); e++) begin
      logic [NREQ-1:0] r;
      logic c;
      r = ((e == 0) || (e == TOTAL + 4)) ? 4'b0001 : 4'b0000;
      c = (e == 5) || (e == 20) || (e == TOTAL + 4);
      tick(r, c);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL clear_gating step %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
    end
    $display("[TB] test_clear_gating done, cause=%b", cause);
  endtask

  task automatic test_async_reset();
    tick(4'b1000, 1'b0);
    for (int e = 0; e < HOLD + GAP + 2; e++) tick('0, 1'b0);
    tests++;
    if (rst_stage_n !== 3'b011) begin
      fails++;
      $display("FAIL async_pre: got stage=%b, expected 011", rst_stage_n);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({rst_stage_n, busy, cause} !== {3'b000, 1'b1, 5'b10000}) begin
      fails++;
      $display("FAIL async_immediate: got stage=%b busy=%b cause=%b, expected stage=000 busy=1 cause=10000",
               rst_stage_n, busy, cause);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= TOTAL + 2; e++) begin
      tick('0, 1'b0);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL async_poweron edge %0d: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    for (int e = 0; e < 800; e++) begin
      logic [NREQ-1:0] r;
      logic c;
      r = ($urandom_range(0, 39) == 0) ? NREQ'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 5) == 0 && e > 0 && req != '0) r = req;  // sometimes hold a request
      c = ($urandom_range(0, 7) == 0);
      tick(r, c);
      tests++;
      if ({rst_stage_n, busy, cause} !== {exp_stage(), exp_busy(), m_cause}) begin
        fails++;
        $display("FAIL random step %0d req=%b clr=%b: got stage=%b busy=%b cause=%b, expected stage=%b busy=%b cause=%b",
                 e, r, c, rst_stage_n, busy, cause, exp_stage(), exp_busy(), m_cause);
      end
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_watchdog();
    test_retrigger();
    test_simultaneous();
    test_clear_gating();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
